// File: rtl/mouse_init_ctrl_pkg.sv
// PS/2 command and response codes, controller states and the init step ROM
// shared by the mouse init sequencer.
package mouse_pkg;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  localparam logic [2:0] LAST_STEP  = 3'd5;
  localparam logic [2:0] BAT_STEP   = 3'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_TX,
    ST_TXACK,
    ST_RX,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic       is_send;
    logic [7:0] data;
  } step_t;

  // Send steps carry the command byte, expect steps the reply to compare against
  function automatic step_t step_rom(input logic [2:0] idx);
    step_t s;
    case (idx)
      3'd0:    s = '{is_send: 1'b1, data: CMD_RESET};
      3'd1:    s = '{is_send: 1'b0, data: RSP_ACK};
      3'd2:    s = '{is_send: 1'b0, data: RSP_BAT};
      3'd3:    s = '{is_send: 1'b0, data: RSP_ID};
      3'd4:    s = '{is_send: 1'b1, data: CMD_ENABLE};
      default: s = '{is_send: 1'b0, data: RSP_ACK};
    endcase
    return s;
  endfunction

  function automatic logic step_is_send(input logic [2:0] idx);
    step_t s;
    s = step_rom(idx);
    return s.is_send;
  endfunction

  function automatic logic [7:0] step_byte(input logic [2:0] idx);
    step_t s;
    s = step_rom(idx);
    return s.data;
  endfunction

endpackage

// File: rtl/mouse_init_ctrl_sync_edge.sv
// Two-flop synchroniser for the PS/2 clock and data pads plus a falling-edge
// detector on the synchronised clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_msclk,
  input  logic i_msdat,
  output logic o_msdat,
  output logic o_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       r_clk_prev;

  // Idle bus level is high, so resetting to 1 avoids a false edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_msclk};
      r_dat_sync <= {r_dat_sync[0], i_msdat};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign o_msdat = r_dat_sync[1];
  assign o_fall  = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/mouse_init_ctrl.sv
// Host-side PS/2 init sequencer: resets the mouse, checks its replies, enables
// streaming and then hands the bus to the mouse receiver.
module mouse_init_ctrl
  import mouse_pkg::*;
#(
  parameter int INHIBIT_CYC  = 5000,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int SELFTEST_CYC = 40000000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       msclk_in,
  input  logic       msdat_in,
  output logic       msclk_oe,
  output logic       msdat_oe,
  output logic       busy,
  output logic       ready,
  output logic       error,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int MAX_A   = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_A > SELFTEST_CYC) ? MAX_A : SELFTEST_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int RW      = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] INH_LAST    = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] BAT_LAST    = CW'(SELFTEST_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_t        r_state;
  logic [2:0]    r_step;
  logic [RW-1:0] r_retry;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bitcnt;
  logic          r_txbit;
  logic [9:0]    r_rxsh;
  logic [7:0]    r_rx_byte;
  logic          r_rx_valid;

  logic          w_dat;
  logic          w_fall;
  logic [7:0]    w_step_byte;
  logic          w_next_send;
  logic [9:0]    w_txframe;
  logic [10:0]   w_frame;
  logic          w_rx_good;
  logic          w_waiting;
  logic          w_timeout;
  logic          w_resend;
  logic          w_fail;
  logic [RW-1:0] w_retry_inc;

  ps2_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_msclk (msclk_in),
    .i_msdat (msdat_in),
    .o_msdat (w_dat),
    .o_fall  (w_fall)
  );

  // Frame assembly and every condition that aborts the current attempt
  always_comb begin
    w_step_byte = step_byte(r_step);
    w_next_send = step_is_send(r_step + 3'd1);
    w_txframe   = {1'b1, ~^w_step_byte, w_step_byte};
    w_frame     = {w_dat, r_rxsh};
    w_rx_good   = !w_frame[0] && w_frame[10] && (^w_frame[9:1]);
    w_waiting   = (r_state == ST_TX) || (r_state == ST_TXACK) || (r_state == ST_RX);
    w_timeout   = w_waiting && !w_fall &&
                  (r_cnt == ((r_step == BAT_STEP) ? BAT_LAST : TO_LAST));
    w_resend    = (r_state == ST_CHECK) && (r_rx_byte == RSP_RESEND) &&
                  ((r_step == 3'd1) || (r_step == LAST_STEP));
    w_fail      = w_timeout ||
                  ((r_state == ST_TXACK) && w_fall && w_dat) ||
                  ((r_state == ST_RX) && w_fall && (r_bitcnt == 4'd10) && !w_rx_good) ||
                  ((r_state == ST_CHECK) && !w_resend && (r_rx_byte != w_step_byte));
    w_retry_inc = r_retry + RW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_step     <= '0;
      r_retry    <= '0;
      r_cnt      <= '0;
      r_bitcnt   <= '0;
      r_txbit    <= 1'b1;
      r_rxsh     <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_cnt      <= (w_fall && (r_state != ST_INHIBIT)) ? '0 : r_cnt + CW'(1);
      if (w_fail || w_resend) begin
        r_retry <= w_retry_inc;
        r_cnt   <= '0;
        if (w_retry_inc == RETRY_LIMIT) begin
          r_state <= ST_ERR;
        end else begin
          r_state <= ST_INHIBIT;
          r_step  <= w_fail ? 3'd0 : r_step - 3'd1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_INHIBIT;
            r_cnt   <= '0;
          end
          ST_INHIBIT: begin
            if (r_cnt == INH_LAST) begin
              r_state <= ST_RTS;
              r_cnt   <= '0;
            end
          end
          ST_RTS: begin
            r_state  <= ST_TX;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_txbit  <= 1'b0;
          end
          // Stop bit already on the line when the count hits 10
          ST_TX: begin
            if (w_fall) begin
              if (r_bitcnt == 4'd10) begin
                r_state <= ST_TXACK;
                r_txbit <= 1'b1;
              end else begin
                r_txbit  <= w_txframe[r_bitcnt];
                r_bitcnt <= r_bitcnt + 4'd1;
              end
            end
          end
          ST_TXACK: begin
            if (w_fall) begin
              r_state  <= ST_RX;
              r_step   <= r_step + 3'd1;
              r_bitcnt <= '0;
            end
          end
          ST_RX: begin
            if (w_fall) begin
              r_rxsh <= w_frame[10:1];
              if (r_bitcnt == 4'd10) begin
                r_rx_byte  <= w_frame[8:1];
                r_rx_valid <= 1'b1;
                r_state    <= ST_CHECK;
              end else begin
                r_bitcnt <= r_bitcnt + 4'd1;
              end
            end
          end
          ST_CHECK: begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            if (r_step == LAST_STEP) begin
              r_state <= ST_DONE;
            end else begin
              r_step  <= r_step + 3'd1;
              r_state <= w_next_send ? ST_INHIBIT : ST_RX;
            end
          end
          ST_DONE, ST_ERR: begin
            if (start) begin
              r_state <= ST_INHIBIT;
              r_step  <= '0;
              r_retry <= '0;
              r_cnt   <= '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign msclk_oe = (r_state == ST_INHIBIT);
  assign msdat_oe = ((r_state == ST_INHIBIT) && (r_cnt == INH_LAST)) ||
                    (r_state == ST_RTS) || ((r_state == ST_TX) && !r_txbit);
  assign busy     = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign ready    = (r_state == ST_DONE);
  assign error    = (r_state == ST_ERR);
  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_mouse_init_ctrl.sv
// Bench for mouse_init_ctrl: a behavioural PS/2 mouse on open-drain lines with
// randomized clock rate and reply gaps, checked against an expected-reply model.
module tb_mouse_init_ctrl;

  localparam int INH = 20;
  localparam int TO  = 400;
  localparam int BAT = 800;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       msclk_in, msdat_in;
  logic       msclk_oe, msdat_oe, busy, ready, error, rx_valid;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_pass = 0;
  int half = 8;
  int inh_cnt = 0;
  logic prev_clk_oe = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];

  assign msclk_in = dev_clk & ~msclk_oe;
  assign msdat_in = dev_dat & ~msdat_oe;

  mouse_init_ctrl #(
    .INHIBIT_CYC (INH),
    .TIMEOUT_CYC (TO),
    .SELFTEST_CYC(BAT),
    .MAX_RETRY   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .msclk_in(msclk_in),
    .msdat_in(msdat_in),
    .msclk_oe(msclk_oe),
    .msdat_oe(msdat_oe),
    .busy    (busy),
    .ready   (ready),
    .error   (error),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  // Record every accepted byte and every new clock-inhibit interval
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_byte);
    if (msclk_oe && !prev_clk_oe) inh_cnt++;
    prev_clk_oe = msclk_oe;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no finish, expected finish before 80000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic odd_par(input logic [7:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  task automatic apply_reset();
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    start   = 1'b0;
    half    = $urandom_range(6, 10);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Device side: wait for the host's request-to-send (clock released, data low)
  task automatic dev_wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (msclk_in && !msdat_in && !msclk_oe) ok = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  // Device clocks in a host frame and acks it; abort_at leaves the clock low early
  task automatic dev_recv(input int abort_at, input int start_at, output logic [7:0] b,
                          output logic par, output logic stp, output logic ack_rel);
    logic [9:0] f;
    f = '0;
    ack_rel = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      dev_clk = 1'b0;
      if (k == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      repeat (half) @(negedge clk);
      if (k <= 10) f[k-1] = msdat_in;
      if (k == 11) ack_rel = !msdat_oe;
      if (k == abort_at) break;
      dev_clk = 1'b1;
      if (k == 11) dev_dat = 1'b0;
      repeat (half) @(negedge clk);
    end
    dev_dat = 1'b1;
    b   = f[7:0];
    par = f[8];
    stp = f[9];
  endtask

  task automatic dev_send(input logic [7:0] b, input bit bad_par);
    logic [10:0] fr;
    repeat ($urandom_range(5, 40)) @(negedge clk);
    fr = {1'b1, odd_par(b) ^ bad_par, b, 1'b0};
    for (int k = 0; k < 11; k++) begin
      dev_dat = fr[k];
      repeat (half) @(negedge clk);
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    if (!bad_par) exp_rx.push_back(b);
  endtask

  // Mouse behaviour: reset answers ack, self-test pass and ID; enable answers ack
  task automatic dev_serve(input logic [7:0] cmd);
    if (cmd == 8'hFF) begin
      dev_send(8'hFA, 1'b0);
      dev_send(8'hAA, 1'b0);
      dev_send(8'h00, 1'b0);
    end else begin
      dev_send(8'hFA, 1'b0);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if ({msclk_oe, msdat_oe, busy, ready, error, rx_valid} !== 6'b0) $display("[TB] FAIL reset_flags: got %b, expected 000000", {msclk_oe, msdat_oe, busy, ready, error, rx_valid}); else n_pass++;
    n_checks++; if (rx_byte !== 8'h00) $display("[TB] FAIL reset_rx_byte: got %h, expected 00", rx_byte); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, msclk_oe} !== 2'b11) $display("[TB] FAIL autostart_inhibit: got %b, expected 11", {busy, msclk_oe}); else n_pass++;
  endtask

  task automatic test_basic_flow();
    logic [7:0] exp_cmd[2];
    logic [7:0] b;
    logic par, stp, ackr;
    bit ok;
    int base;
    exp_cmd = '{8'hFF, 8'hF4};
    apply_reset();
    base = rx_q.size();
    for (int c = 0; c < 2; c++) begin
      dev_wait_rts(ok);
      n_checks++; if (!ok) $display("[TB] FAIL basic_rts: got no request-to-send, expected one for %h", exp_cmd[c]); else n_pass++;
      dev_recv(0, 0, b, par, stp, ackr);
      n_checks++; if (b !== exp_cmd[c]) $display("[TB] FAIL basic_cmd: got %h, expected %h", b, exp_cmd[c]); else n_pass++;
      n_checks++; if (par !== odd_par(exp_cmd[c])) $display("[TB] FAIL basic_parity: got %b, expected %b", par, odd_par(exp_cmd[c])); else n_pass++;
      n_checks++; if ({stp, ackr} !== 2'b11) $display("[TB] FAIL basic_stop_ack: got %b, expected 11", {stp, ackr}); else n_pass++;
      dev_serve(exp_cmd[c]);
    end
    repeat (4) @(negedge clk);
    n_checks++; if (rx_q.size() - base !== 4) $display("[TB] FAIL basic_rx_count: got %0d, expected 4", rx_q.size() - base); else n_pass++;
    n_checks++; if ({ready, error, busy, msclk_oe, msdat_oe} !== 5'b10000) $display("[TB] FAIL basic_done: got %b, expected 10000", {ready, error, busy, msclk_oe, msdat_oe}); else n_pass++;
    n_checks++; if (rx_byte !== 8'hFA) $display("[TB] FAIL basic_last_byte: got %h, expected fa", rx_byte); else n_pass++;
  endtask

  task automatic test_resend();
    logic [7:0] seq[3];
    logic [7:0] b;
    logic par, stp, ackr;
    bit ok;
    seq = '{8'hFF, 8'hFF, 8'hF4};
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      dev_wait_rts(ok);
      n_checks++; if (!ok) $display("[TB] FAIL resend_rts: got no request-to-send, expected one for %h", seq[c]); else n_pass++;
      dev_recv(0, 0, b, par, stp, ackr);
      n_checks++; if ({b, par} !== {seq[c], odd_par(seq[c])}) $display("[TB] FAIL resend_cmd: got %h/%b, expected %h/%b", b, par, seq[c], odd_par(seq[c])); else n_pass++;
      if (c == 0) dev_send(8'hFE, 1'b0);
      else dev_serve(seq[c]);
    end
    repeat (4) @(negedge clk);
    n_checks++; if ({ready, error} !== 2'b10) $display("[TB] FAIL resend_done: got %b, expected 10", {ready, error}); else n_pass++;
  endtask

  task automatic test_timeout_error();
    int base;
    apply_reset();
    base = inh_cnt;
    repeat (2 * (INH + TO)) @(negedge clk);
    n_checks++; if ({error, busy} !== 2'b01) $display("[TB] FAIL timeout_still_trying: got %b, expected 01", {error, busy}); else n_pass++;
    repeat (INH + TO + 60) @(negedge clk);
    n_checks++; if ({error, ready, busy, msclk_oe, msdat_oe} !== 5'b10000) $display("[TB] FAIL timeout_err: got %b, expected 10000", {error, ready, busy, msclk_oe, msdat_oe}); else n_pass++;
    n_checks++; if (inh_cnt - base !== 3) $display("[TB] FAIL timeout_attempts: got %0d, expected 3", inh_cnt - base); else n_pass++;
  endtask

  task automatic test_bad_parity();
    logic [7:0] b;
    logic par, stp, ackr;
    bit ok;
    int base;
    apply_reset();
    dev_wait_rts(ok);
    dev_recv(0, 0, b, par, stp, ackr);
    n_checks++; if (b !== 8'hFF) $display("[TB] FAIL parity_first_cmd: got %h, expected ff", b); else n_pass++;
    dev_send(8'hFA, 1'b0);
    base = rx_q.size();
    dev_send(8'hAA, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (rx_q.size() !== base) $display("[TB] FAIL parity_no_valid: got %0d pulses, expected 0", rx_q.size() - base); else n_pass++;
    for (int c = 0; c < 2; c++) begin
      dev_wait_rts(ok);
      dev_recv(0, 0, b, par, stp, ackr);
      n_checks++; if ((!ok) || (b !== ((c == 0) ? 8'hFF : 8'hF4))) $display("[TB] FAIL parity_retry_cmd: got %h (rts %0d), expected %h", b, ok, (c == 0) ? 8'hFF : 8'hF4); else n_pass++;
      dev_serve(b);
    end
    repeat (4) @(negedge clk);
    n_checks++; if ({ready, error} !== 2'b10) $display("[TB] FAIL parity_done: got %b, expected 10", {ready, error}); else n_pass++;
  endtask

  task automatic test_async_reset_mid_tx();
    logic [7:0] b;
    logic par, stp, ackr;
    bit ok;
    apply_reset();
    dev_wait_rts(ok);
    dev_recv(5, 0, b, par, stp, ackr);
    n_checks++; if (busy !== 1'b1) $display("[TB] FAIL arst_pre_busy: got %b, expected 1", busy); else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++; if ({msclk_oe, msdat_oe, busy} !== 3'b000) $display("[TB] FAIL arst_release: got %b, expected 000", {msclk_oe, msdat_oe, busy}); else n_pass++;
    dev_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (msclk_oe !== 1'b1) $display("[TB] FAIL arst_inhibit: got %b, expected 1", msclk_oe); else n_pass++;
    for (int c = 0; c < 2; c++) begin
      dev_wait_rts(ok);
      dev_recv(0, 0, b, par, stp, ackr);
      n_checks++; if ((!ok) || (b !== ((c == 0) ? 8'hFF : 8'hF4))) $display("[TB] FAIL arst_cmd: got %h (rts %0d), expected %h", b, ok, (c == 0) ? 8'hFF : 8'hF4); else n_pass++;
      dev_serve(b);
    end
    repeat (4) @(negedge clk);
    n_checks++; if ({ready, error} !== 2'b10) $display("[TB] FAIL arst_done: got %b, expected 10", {ready, error}); else n_pass++;
  endtask

  task automatic test_restart();
    logic [7:0] b;
    logic par, stp, ackr;
    bit ok;
    int base;
    half = $urandom_range(6, 10);
    base = rx_q.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if ({ready, busy} !== 2'b01) $display("[TB] FAIL restart_clear: got %b, expected 01", {ready, busy}); else n_pass++;
    for (int c = 0; c < 2; c++) begin
      dev_wait_rts(ok);
      dev_recv(0, (c == 0) ? 3 : 0, b, par, stp, ackr);
      n_checks++; if ((!ok) || (b !== ((c == 0) ? 8'hFF : 8'hF4)) || (ackr !== 1'b1)) $display("[TB] FAIL restart_cmd: got %h ack %b (rts %0d), expected %h ack 1", b, ackr, ok, (c == 0) ? 8'hFF : 8'hF4); else n_pass++;
      dev_serve(b);
    end
    repeat (4) @(negedge clk);
    n_checks++; if (rx_q.size() - base !== 4) $display("[TB] FAIL restart_rx_count: got %0d, expected 4", rx_q.size() - base); else n_pass++;
    n_checks++; if ({ready, error, busy} !== 3'b100) $display("[TB] FAIL restart_done: got %b, expected 100", {ready, error, busy}); else n_pass++;
  endtask

  task automatic test_rx_stream();
    bit same;
    same = (rx_q.size() == exp_rx.size());
    for (int i = 0; i < rx_q.size() && same; i++) same = (rx_q[i] === exp_rx[i]);
    n_checks++; if (!same) $display("[TB] FAIL rx_stream: got %0d bytes, expected %0d matching bytes", rx_q.size(), exp_rx.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_resend();
    test_timeout_error();
    test_bad_parity();
    test_async_reset_mid_tx();
    test_restart();
    test_rx_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
